ids_pkt_filter: RTL and testbench



---
 rtl/ids_pkt_filter_pkg.sv | 16 +
 rtl/ids_pkt_filter_if.sv | 25 ++
 rtl/ids_pkt_store.sv | 25 ++
 rtl/ids_pkt_filter.sv | 131 +++++++++++++
 tb/tb_ids_pkt_filter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ids_pkt_filter_pkg.sv
// Shared encodings and constants for the IDS packet filter stage.
package ids_pkt_filter_pkg;

  localparam logic [7:0] CTRL_MODULE_HDR = 8'hFF;
  localparam logic [7:0] CTRL_BODY       = 8'h00;

  // Free-word threshold below which upstream is stopped (covers its stop latency).
  localparam int IN_RDY_MARGIN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } wr_state_t;

endpackage

// File: rtl/ids_pkt_filter_if.sv
// Word-stream bus into and out of the packet filter.
interface ids_pkt_filter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic                  drop_req;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (
    output in_data, in_ctrl, in_wr, drop_req, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, drop_req, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/ids_pkt_store.sv
// Simple dual-port word store with registered read; read register clears on reset.
module ids_pkt_store #(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [1 << ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ids_pkt_filter.sv
// Store-and-forward packet filter: buffers each packet and, at its last word,
// commits it for output or rewinds it away on drop request or overflow.
module ids_pkt_filter
  import ids_pkt_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_BITS  = 9
) (
  input  logic                clk,
  input  logic                reset,
  ids_pkt_filter_if.slave     bus,
  input  logic                cnt_clear,
  output logic [31:0]         pkts_passed,
  output logic [31:0]         pkts_dropped
);
  localparam int W = CTRL_WIDTH + DATA_WIDTH;
  typedef logic [ADDR_BITS:0] ptr_t;
  localparam ptr_t DEPTH  = ptr_t'(1 << ADDR_BITS);
  localparam ptr_t MARGIN = ptr_t'(IN_RDY_MARGIN);
  localparam logic [CTRL_WIDTH-1:0] HDR_CODE  = CTRL_WIDTH'(CTRL_MODULE_HDR);
  localparam logic [CTRL_WIDTH-1:0] BODY_CODE = CTRL_WIDTH'(CTRL_BODY);

  ptr_t wr_ptr, commit_ptr, rd_ptr, used, free_w;
  logic full, pending, rd_en;
  wr_state_t state, state_nxt;
  logic accept, is_last, store_en, in_pkt, discard, commit;
  logic drop_f, ovf_f, is_hdr, is_body;
  logic [W-1:0] rdata;

  // Occupancy uses pre-update pointers; the extra pointer bit tells full from empty.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == DEPTH);
  assign free_w  = DEPTH - used;
  assign pending = (rd_ptr != commit_ptr);
  assign rd_en   = bus.out_rdy && pending;

  // Only stall upstream when draining is possible; otherwise let an oversize packet overflow.
  assign bus.in_rdy = !((free_w < MARGIN) && pending);

  assign is_hdr  = (bus.in_ctrl == HDR_CODE);
  assign is_body = (bus.in_ctrl == BODY_CODE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    is_last   = 1'b0;
    case (state)
      ST_IDLE: if (bus.in_wr && is_hdr) begin
        accept    = 1'b1;
        state_nxt = ST_HDR;
      end
      ST_HDR: if (bus.in_wr) begin
        accept = 1'b1;
        if (is_body)      state_nxt = ST_BODY;
        else if (!is_hdr) begin
          is_last   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_BODY: if (bus.in_wr) begin
        accept = 1'b1;
        if (!is_body) begin
          is_last   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign store_en = accept && !full;
  assign in_pkt   = (state != ST_IDLE) || accept;
  assign discard  = is_last && (drop_f || bus.drop_req || ovf_f || full);
  assign commit   = is_last && !discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      drop_f     <= 1'b0;
      ovf_f      <= 1'b0;
      bus.out_wr <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.out_wr <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      if (discard) begin
        wr_ptr <= commit_ptr;
      end else if (commit) begin
        wr_ptr     <= wr_ptr + ptr_t'(1);
        commit_ptr <= wr_ptr + ptr_t'(1);
      end else if (store_en) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (is_last) begin
        drop_f <= 1'b0;
        ovf_f  <= 1'b0;
      end else if (in_pkt) begin
        drop_f <= drop_f || bus.drop_req;
        ovf_f  <= ovf_f || (accept && full);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      pkts_passed  <= '0;
      pkts_dropped <= '0;
    end else begin
      if (commit)  pkts_passed  <= pkts_passed + 32'd1;
      if (discard) pkts_dropped <= pkts_dropped + 32'd1;
    end
  end

  ids_pkt_store #(.WIDTH(W), .ADDR_BITS(ADDR_BITS)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (store_en),
    .waddr (wr_ptr[ADDR_BITS-1:0]),
    .wdata ({bus.in_ctrl, bus.in_data}),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_BITS-1:0]),
    .rdata (rdata)
  );

  assign bus.out_ctrl = rdata[W-1 -: CTRL_WIDTH];
  assign bus.out_data = rdata[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_ids_pkt_filter.sv
// Bench for ids_pkt_filter: queue-based packet model compared every cycle,
// plus directed edge cases and a small-store instance for oversize packets.
module tb_ids_pkt_filter;
  import ids_pkt_filter_pkg::*;
  localparam int DW = 64, CW = 8, AB = 9, DEPTH = 512;

  typedef struct packed { logic [7:0] c; logic [63:0] d; } word_t;

  logic clk = 1'b0, reset = 1'b1, cnt_clear = 1'b0;
  logic [31:0] pp, pd, spp, spd;
  logic s_clear = 1'b0;
  int n_chk = 0, n_fail = 0, n_out = 0, s_outs = 0, rdy_mode = 1;
  bit s_rdy_low = 0, obey = 1;
  logic [63:0] first_d, s_first_out;

  ids_pkt_filter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();
  ids_pkt_filter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) sbus ();

  ids_pkt_filter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .cnt_clear(cnt_clear),
    .pkts_passed(pp), .pkts_dropped(pd));

  ids_pkt_filter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_BITS(4)) dut_s (
    .clk(clk), .reset(reset), .bus(sbus), .cnt_clear(s_clear),
    .pkts_passed(spp), .pkts_dropped(spd));

  always #5 clk = ~clk;

  task automatic check(string nm, logic [95:0] act, logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  word_t cq[$];    // committed, not yet read
  word_t part[$];  // words of the packet being received
  int m_state = 0; // 0 outside packet, 1 in headers, 2 in body
  bit m_drop = 0, m_ovf = 0, exp_vld = 0;
  word_t exp_w;
  logic [31:0] m_pass = 0, m_dropc = 0;

  function automatic int m_occ();
    return part.size() + cq.size();
  endfunction

  always @(posedge clk) begin
    bit full, take, last, in_pkt, hdr, body;
    word_t w;
    full = (m_occ() == DEPTH);
    if (reset) begin
      cq.delete(); part.delete();
      m_state = 0; m_drop = 0; m_ovf = 0; exp_vld = 0; m_pass = 0; m_dropc = 0;
    end else begin
      exp_vld = bus.out_rdy && cq.size() > 0;
      if (exp_vld) exp_w = cq.pop_front();
      take = 0; last = 0;
      w = '{c: bus.in_ctrl, d: bus.in_data};
      hdr = (w.c == 8'hFF); body = (w.c == 8'h00);
      in_pkt = (m_state != 0);
      if (bus.in_wr) begin
        if (m_state == 0) begin
          if (hdr) begin take = 1; m_state = 1; end
        end else begin
          take = 1;
          if (m_state == 1 && body) m_state = 2;
          else if (!(m_state == 1 && hdr) && !(m_state == 2 && body)) last = 1;
        end
      end
      if (in_pkt || take) m_drop = m_drop | bus.drop_req;
      if (last) begin
        if (m_drop || m_ovf || full) begin
          part.delete();
          if (!cnt_clear) m_dropc++;
        end else begin
          part.push_back(w);
          foreach (part[i]) cq.push_back(part[i]);
          part.delete();
          if (!cnt_clear) m_pass++;
        end
        m_drop = 0; m_ovf = 0; m_state = 0;
      end else if (take) begin
        if (full) m_ovf = 1;
        else part.push_back(w);
      end
      if (cnt_clear) begin m_pass = 0; m_dropc = 0; end
    end
  end

  // Compare process: every cycle once the first reset edge has passed.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !(((DEPTH - m_occ()) < 3) && cq.size() > 0);
    check("out_wr", bus.out_wr, exp_vld);
    if (exp_vld) check("out_word", {bus.out_ctrl, bus.out_data}, exp_w);
    check("in_rdy", bus.in_rdy, exp_rdy);
    check("pkts_passed", pp, m_pass);
    check("pkts_dropped", pd, m_dropc);
    if (bus.out_wr) n_out++;
    if (sbus.out_wr) begin
      if (s_outs == 0) s_first_out = sbus.out_data;
      s_outs++;
    end
    if (!sbus.in_rdy) s_rdy_low = 1;
  end

  always @(negedge clk) begin
    if (rdy_mode == 2) bus.out_rdy = 1'($urandom_range(0, 1));
    else bus.out_rdy = (rdy_mode == 1);
  end

  // ---------------- stimulus ----------------
  task automatic send_pkt(int nhdr, int nbody, logic [7:0] lastc, int drop_idx, bit clr, bit gaps);
    int n = nhdr + nbody + 1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] c;
      logic [63:0] d;
      int guard = 0;
      c = (i < nhdr) ? 8'hFF : ((i == n - 1) ? lastc : 8'h00);
      d = {$urandom, $urandom};
      if (i == 0) first_d = d;
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      while (obey && !bus.in_rdy && guard < 5000) begin @(negedge clk); guard++; end
      if (guard >= 5000) check("in_rdy_stall_timeout", 1, 0);
      bus.in_wr = 1; bus.in_data = d; bus.in_ctrl = c;
      bus.drop_req = (i == drop_idx); cnt_clear = clr && (i == n - 1);
      @(negedge clk);
      bus.in_wr = 0; bus.drop_req = 0; cnt_clear = 0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((cq.size() > 0 || exp_vld) && g < 3000) begin @(negedge clk); g++; end
    if (g >= 3000) check("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    bus.in_wr = 0; bus.in_data = '0; bus.in_ctrl = '0; bus.drop_req = 0; bus.out_rdy = 1;
    sbus.in_wr = 0; sbus.in_data = '0; sbus.in_ctrl = '0; sbus.drop_req = 0; sbus.out_rdy = 1;
    repeat (2) @(negedge clk);
    check("rst_out_wr", bus.out_wr, 0);
    check("rst_out_data", {bus.out_ctrl, bus.out_data}, 0);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_cnt", {pp, pd}, 0);
    reset = 0;
    @(negedge clk);

    // Pass-through with latency pin.
    base = n_out;
    send_pkt(1, 6, 8'h80, -1, 0, 0);
    check("lat_cycle1_out_wr", bus.out_wr, 0);
    @(negedge clk);
    check("lat_cycle2_out_wr", bus.out_wr, 1);
    check("lat_first_word", {bus.out_ctrl, bus.out_data}, {8'hFF, first_d});
    drain();
    check("pt_words", n_out - base, 8);
    check("pt_passed", pp, 1);

    // Drop on last word, then a clean packet.
    cnt_clear = 1; @(negedge clk); cnt_clear = 0;
    base = n_out;
    send_pkt(1, 6, 8'h80, 7, 0, 0);
    drain();
    check("drop_words", n_out - base, 0);
    check("drop_dropped", pd, 1);
    send_pkt(1, 6, 8'h80, -1, 0, 0);
    drain();
    check("after_drop_words", n_out - base, 8);
    check("after_drop_passed", pp, 1);

    // Backpressure: 3 x 200 words with the output stalled until in_rdy falls.
    rdy_mode = 0; base = n_out;
    fork
      for (int p = 0; p < 3; p++) send_pkt(1, 198, 8'h01, -1, 0, 0);
      begin
        int g = 0;
        while (bus.in_rdy && g < 3000) begin @(negedge clk); g++; end
        check("bp_in_rdy_fell", bus.in_rdy, 0);
        repeat (20) @(negedge clk);
        rdy_mode = 1;
      end
    join
    drain();
    check("bp_words", n_out - base, 600);

    // Randomized traffic.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int nb = $urandom_range(0, 50);
      int nh = $urandom_range(1, 2);
      int di = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb + nh) : -1;
      if ($urandom_range(0, 7) == 0) begin
        bus.in_wr = 1; bus.in_ctrl = 8'h00; bus.in_data = {$urandom, $urandom};
        @(negedge clk); bus.in_wr = 0;
      end
      send_pkt(nh, nb, 8'($urandom_range(1, 254)), di, 0, 1);
    end
    rdy_mode = 1;
    drain();

    // Counter wrap and clear-vs-increment priority.
    @(posedge clk); #2;
    force dut.pkts_passed = 32'hFFFF_FFFF;
    m_pass = 32'hFFFF_FFFF;
    #1 release dut.pkts_passed;
    @(negedge clk);
    send_pkt(1, 2, 8'h0F, -1, 0, 0);
    drain();
    check("wrap_passed", pp, 0);
    send_pkt(1, 2, 8'h0F, -1, 0, 0);
    send_pkt(1, 2, 8'h0F, -1, 1, 0);
    drain();
    check("clear_prio_passed", pp, 0);

    // Reset in the middle of a packet.
    base = n_out;
    send_pkt(1, 1, 8'h00, -1, 0, 0);  // three words, no last (0x00 keeps body open)
    reset = 1;
    @(negedge clk);
    check("mid_rst_out_wr", bus.out_wr, 0);
    check("mid_rst_out_data", {bus.out_ctrl, bus.out_data}, 0);
    check("mid_rst_in_rdy", bus.in_rdy, 1);
    check("mid_rst_cnt", {pp, pd}, 0);
    reset = 0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_stale", n_out - base, 0);

    // Oversize packet into the 16-word store.
    for (int i = 0; i < 40; i++) begin
      sbus.in_wr = 1; sbus.in_data = 64'(i);
      sbus.in_ctrl = (i == 0) ? 8'hFF : ((i == 39) ? 8'h01 : 8'h00);
      @(negedge clk);
    end
    sbus.in_wr = 0;
    repeat (5) @(negedge clk);
    check("ovs_in_rdy_stayed_high", s_rdy_low, 0);
    check("ovs_dropped", spd, 1);
    check("ovs_passed", spp, 0);
    check("ovs_no_output", s_outs, 0);
    for (int i = 0; i < 3; i++) begin
      sbus.in_wr = 1; sbus.in_data = 64'(100 + i);
      sbus.in_ctrl = (i == 0) ? 8'hFF : ((i == 2) ? 8'h02 : 8'h00);
      @(negedge clk);
    end
    sbus.in_wr = 0;
    repeat (10) @(negedge clk);
    check("ovs_after_words", s_outs, 3);
    check("ovs_after_first", s_first_out, 100);
    check("ovs_after_passed", spp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
